// File: rtl/arb_pkg.sv
// ----------------------------------------------------------------------------
// arb_pkg
//   Shared types and helpers for the data-memory arbiter.
//   - arb_state_e : arbiter state (IDLE, WAIT, HOLD)
//   - mem_sel_w() : address width for a given number of memory words
// ----------------------------------------------------------------------------
package arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_WAIT = 2'd1,
        ARB_HOLD = 2'd2
    } arb_state_e;

    // A single-word memory still needs one address bit on the bus.
    function automatic int mem_sel_w(input int num_mem);
        return (num_mem > 1) ? $clog2(num_mem) : 1;
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// ----------------------------------------------------------------------------
// dmem_arbiter_if
//   Bundles the core store port, the host valid/ready port and the flat
//   memory view of the data-memory arbiter.
//   slave  : the arbiter (consumes i_*, drives o_*)
//   master : the core/host side (drives i_*, observes o_*)
//
//   Host handshake: a request is transferred on a rising edge where
//   i_host_valid && o_host_ready. The host keeps valid and its payload
//   stable until that edge; o_host_ready may depend combinationally on the
//   core store enable. Read data comes back with a one-cycle o_host_rvalid
//   pulse and o_host_rdata holds until the next read completes.
// ----------------------------------------------------------------------------
interface dmem_arbiter_if #(
    parameter int NUM_MEM   = 16,
    parameter int REG_WIDTH = 32
);
    localparam int MEM_SELECT = arb_pkg::mem_sel_w(NUM_MEM);

    logic                         i_core_we;
    logic [MEM_SELECT-1:0]        i_core_sel;
    logic [REG_WIDTH-1:0]         i_core_word;
    logic [NUM_MEM*REG_WIDTH-1:0] o_mem;
    logic                         o_core_hold;
    logic                         i_host_valid;
    logic                         i_host_we;
    logic [MEM_SELECT-1:0]        i_host_sel;
    logic [REG_WIDTH-1:0]         i_host_wdata;
    logic                         o_host_ready;
    logic                         o_host_rvalid;
    logic [REG_WIDTH-1:0]         o_host_rdata;
    logic                         o_err;

    modport slave (
        input  i_core_we, i_core_sel, i_core_word,
        input  i_host_valid, i_host_we, i_host_sel, i_host_wdata,
        output o_mem, o_core_hold, o_host_ready, o_host_rvalid, o_host_rdata, o_err
    );

    modport master (
        output i_core_we, i_core_sel, i_core_word,
        output i_host_valid, i_host_we, i_host_sel, i_host_wdata,
        input  o_mem, o_core_hold, o_host_ready, o_host_rvalid, o_host_rdata, o_err
    );

endinterface

// File: rtl/arb_starve_fsm.sv
// ----------------------------------------------------------------------------
// arb_starve_fsm
//   Decides who owns the single memory write port. The core has fixed
//   priority; a blocked host request is counted and, after MAX_WAIT
//   consecutive blocked cycles, the core is asked to hold for one grant.
// Ports
//   clk, rst      : clock, asynchronous active-low reset
//   i_core_we     : core store enable
//   i_host_valid  : host request valid
//   o_host_ready  : host grant (combinational)
//   o_core_hold   : registered freeze request to the core (high in HOLD)
//   o_state       : current state, for observation
// ----------------------------------------------------------------------------
module arb_starve_fsm
    import arb_pkg::*;
#(
    parameter int MAX_WAIT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_core_we,
    input  logic       i_host_valid,
    output logic       o_host_ready,
    output logic       o_core_hold,
    output arb_state_e o_state
);
    localparam int               CNT_W    = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);

    arb_state_e       state;
    logic [CNT_W-1:0] wait_cnt;
    logic             blocked;

    // In HOLD the host owns the port no matter what the core does.
    assign o_host_ready = (state == ARB_HOLD) || !i_core_we;
    assign blocked      = i_host_valid && !o_host_ready;
    assign o_state      = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ARB_IDLE;
            wait_cnt    <= '0;
            o_core_hold <= 1'b0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (blocked) begin
                        if (MAX_WAIT == 1) begin
                            state       <= ARB_HOLD;
                            o_core_hold <= 1'b1;
                            wait_cnt    <= '0;
                        end else begin
                            state    <= ARB_WAIT;
                            wait_cnt <= CNT_ONE;
                        end
                    end
                end
                ARB_WAIT: begin
                    // Not blocked here means either accepted or valid dropped.
                    if (!blocked) begin
                        state    <= ARB_IDLE;
                        wait_cnt <= '0;
                    end else if (wait_cnt == CNT_LAST) begin
                        state       <= ARB_HOLD;
                        o_core_hold <= 1'b1;
                        wait_cnt    <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_ONE;
                    end
                end
                ARB_HOLD: begin
                    // Ready is 1 here, so any cycle is an accept or a drop.
                    state       <= ARB_IDLE;
                    o_core_hold <= 1'b0;
                    wait_cnt    <= '0;
                end
                default: begin
                    state       <= ARB_IDLE;
                    o_core_hold <= 1'b0;
                    wait_cnt    <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// ----------------------------------------------------------------------------
// dmem_arbiter
//   Owns the core's data memory and shares its single write port between
//   the core store port (fixed priority) and a host/loader port. A
//   starvation FSM forces a core hold so the host always gets through.
// Ports
//   clk     : clock, all state on rising edge
//   rst     : asynchronous active-low reset
//   bus     : dmem_arbiter_if.slave (core store, host handshake, o_mem,
//             o_core_hold, o_err)
//   o_state : arbiter state, for observation
// ----------------------------------------------------------------------------
module dmem_arbiter
    import arb_pkg::*;
#(
    parameter int NUM_MEM   = 16,
    parameter int REG_WIDTH = 32,
    parameter int MAX_WAIT  = 4
) (
    input  logic            clk,
    input  logic            rst,
    dmem_arbiter_if.slave   bus,
    output arb_state_e      o_state
);
    localparam int                  MEM_SELECT = mem_sel_w(NUM_MEM);
    localparam logic [MEM_SELECT:0] NUM_MEM_L  = (MEM_SELECT + 1)'(NUM_MEM);

    logic [REG_WIDTH-1:0]  mem [NUM_MEM];
    arb_state_e            state;
    logic                  host_ready;
    logic                  core_hold;
    logic                  host_accept;
    logic                  core_wr;
    logic                  host_wr;
    logic                  host_rd;
    logic                  wr_en;
    logic [MEM_SELECT-1:0] wr_sel;
    logic [REG_WIDTH-1:0]  wr_data;
    logic                  wr_in_range;
    logic                  rd_in_range;
    logic                  host_rvalid;
    logic [REG_WIDTH-1:0]  host_rdata;
    logic                  err;

    arb_starve_fsm #(.MAX_WAIT(MAX_WAIT)) u_fsm (
        .clk          (clk),
        .rst          (rst),
        .i_core_we    (bus.i_core_we),
        .i_host_valid (bus.i_host_valid),
        .o_host_ready (host_ready),
        .o_core_hold  (core_hold),
        .o_state      (state)
    );

    assign host_accept = bus.i_host_valid && host_ready;
    // Core stores issued while the core is asked to hold are dropped.
    assign core_wr     = bus.i_core_we && (state != ARB_HOLD);
    assign host_wr     = host_accept && bus.i_host_we;
    assign host_rd     = host_accept && !bus.i_host_we;

    // The grant makes core_wr and host_wr mutually exclusive.
    always_comb begin
        wr_en   = core_wr || host_wr;
        wr_sel  = bus.i_core_sel;
        wr_data = bus.i_core_word;
        if (host_wr) begin
            wr_sel  = bus.i_host_sel;
            wr_data = bus.i_host_wdata;
        end
    end

    // Only matters for non-power-of-two NUM_MEM.
    assign wr_in_range = {1'b0, wr_sel} < NUM_MEM_L;
    assign rd_in_range = {1'b0, bus.i_host_sel} < NUM_MEM_L;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < NUM_MEM; k++) mem[k] <= '0;
        end else if (wr_en && wr_in_range) begin
            mem[wr_sel] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            host_rvalid <= 1'b0;
            host_rdata  <= '0;
            err         <= 1'b0;
        end else begin
            host_rvalid <= host_rd;
            if (host_rd) host_rdata <= rd_in_range ? mem[bus.i_host_sel] : '0;
            if (bus.i_core_we && (state == ARB_HOLD)) err <= 1'b1;
        end
    end

    for (genvar k = 0; k < NUM_MEM; k++) begin : g_mem_out
        assign bus.o_mem[k*REG_WIDTH +: REG_WIDTH] = mem[k];
    end

    assign bus.o_host_ready  = host_ready;
    assign bus.o_core_hold   = core_hold;
    assign bus.o_host_rvalid = host_rvalid;
    assign bus.o_host_rdata  = host_rdata;
    assign bus.o_err         = err;
    assign o_state           = state;

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;
    import arb_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.NUM_MEM(16), .REG_WIDTH(32)) bus16 ();
    dmem_arbiter_if #(.NUM_MEM(12), .REG_WIDTH(32)) bus12 ();
    arb_state_e st16, st12;

    dmem_arbiter #(.NUM_MEM(16), .REG_WIDTH(32), .MAX_WAIT(4)) dut16 (
        .clk(clk), .rst(rst), .bus(bus16), .o_state(st16)
    );
    dmem_arbiter #(.NUM_MEM(12), .REG_WIDTH(32), .MAX_WAIT(1)) dut12 (
        .clk(clk), .rst(rst), .bus(bus12), .o_state(st12)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    function automatic logic [31:0] w16(input int k);
        return bus16.o_mem[k*32 +: 32];
    endfunction

    function automatic logic [31:0] w12(input int k);
        return bus12.o_mem[k*32 +: 32];
    endfunction

    // ---------------- driver tasks ----------------
    task automatic idle16();
        bus16.i_core_we = 0; bus16.i_core_sel = '0; bus16.i_core_word = '0;
        bus16.i_host_valid = 0; bus16.i_host_we = 0; bus16.i_host_sel = '0; bus16.i_host_wdata = '0;
    endtask

    task automatic idle12();
        bus12.i_core_we = 0; bus12.i_core_sel = '0; bus12.i_core_word = '0;
        bus12.i_host_valid = 0; bus12.i_host_we = 0; bus12.i_host_sel = '0; bus12.i_host_wdata = '0;
    endtask

    task automatic host16(input logic we, input logic [3:0] sel, input logic [31:0] d);
        bus16.i_host_valid = 1; bus16.i_host_we = we; bus16.i_host_sel = sel; bus16.i_host_wdata = d;
    endtask

    task automatic host12(input logic we, input logic [3:0] sel, input logic [31:0] d);
        bus12.i_host_valid = 1; bus12.i_host_we = we; bus12.i_host_sel = sel; bus12.i_host_wdata = d;
    endtask

    // Drives core+host contention on dut16 for 4 cycles, ending at the negedge in HOLD.
    task automatic starve16(input logic [3:0] core_sel, input logic [3:0] hsel, input logic [31:0] hdata);
        @(negedge clk);
        host16(1'b1, hsel, hdata);
        bus16.i_core_we = 1; bus16.i_core_sel = core_sel;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            bus16.i_core_word = 32'h100 + i;
            #1;
            tests_run++;
            if (bus16.o_host_ready !== 1'b0) begin
                tests_failed++; $display("FAIL starve_blocked[%0d] ready got=%0b exp=0", i, bus16.o_host_ready);
            end
            tests_run++;
            if (bus16.o_core_hold !== 1'b0) begin
                tests_failed++; $display("FAIL starve_nohold[%0d] hold got=%0b exp=0", i, bus16.o_core_hold);
            end
        end
        @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        idle16(); idle12();
        rst = 0;
        repeat (2) @(negedge clk);
        tests_run++;
        if (bus16.o_mem !== '0 || bus12.o_mem !== '0) begin
            tests_failed++; $display("FAIL reset_mem got16=%0h got12=%0h exp=0", bus16.o_mem, bus12.o_mem);
        end
        tests_run++;
        if ({bus16.o_core_hold, bus16.o_host_rvalid, bus16.o_err} !== 3'b000 || bus16.o_host_rdata !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_outs hold/rvalid/err got=%0b%0b%0b rdata=%0h exp=000 0",
                     bus16.o_core_hold, bus16.o_host_rvalid, bus16.o_err, bus16.o_host_rdata);
        end
        tests_run++;
        if (st16 !== ARB_IDLE || st12 !== ARB_IDLE) begin
            tests_failed++; $display("FAIL reset_state got=%0d/%0d exp=0", st16, st12);
        end
        tests_run++;
        if (bus16.o_host_ready !== 1'b1) begin
            tests_failed++; $display("FAIL reset_ready got=%0b exp=1", bus16.o_host_ready);
        end
        rst = 1;
    endtask

    task automatic test_basic_rw();
        @(negedge clk);
        host16(1'b1, 4'd3, 32'hA5);
        #1;
        tests_run++;
        if (bus16.o_host_ready !== 1'b1) begin
            tests_failed++; $display("FAIL basic_ready got=%0b exp=1", bus16.o_host_ready);
        end
        @(negedge clk);
        tests_run++;
        if (w16(3) !== 32'hA5) begin
            tests_failed++; $display("FAIL basic_write word3 got=%0h exp=a5", w16(3));
        end
        host16(1'b0, 4'd3, 32'h0);
        @(negedge clk);
        tests_run++;
        if (bus16.o_host_rvalid !== 1'b1 || bus16.o_host_rdata !== 32'hA5) begin
            tests_failed++;
            $display("FAIL basic_read rvalid=%0b rdata=%0h exp=1 a5", bus16.o_host_rvalid, bus16.o_host_rdata);
        end
        idle16();
        @(negedge clk);
        tests_run++;
        if (bus16.o_host_rvalid !== 1'b0 || bus16.o_host_rdata !== 32'hA5) begin
            tests_failed++;
            $display("FAIL basic_rdata_hold rvalid=%0b rdata=%0h exp=0 a5", bus16.o_host_rvalid, bus16.o_host_rdata);
        end
    endtask

    task automatic test_core_priority();
        @(negedge clk);
        bus16.i_core_we = 1; bus16.i_core_sel = 4'd2; bus16.i_core_word = 32'h11;
        host16(1'b1, 4'd2, 32'h22);
        #1;
        tests_run++;
        if (bus16.o_host_ready !== 1'b0) begin
            tests_failed++; $display("FAIL prio_blocked ready got=%0b exp=0", bus16.o_host_ready);
        end
        @(negedge clk);
        tests_run++;
        if (w16(2) !== 32'h11 || st16 !== ARB_WAIT) begin
            tests_failed++; $display("FAIL prio_core_wins word2=%0h state=%0d exp=11 1", w16(2), st16);
        end
        bus16.i_core_we = 0;
        #1;
        tests_run++;
        if (bus16.o_host_ready !== 1'b1) begin
            tests_failed++; $display("FAIL prio_released ready got=%0b exp=1", bus16.o_host_ready);
        end
        @(negedge clk);
        tests_run++;
        if (w16(2) !== 32'h22 || st16 !== ARB_IDLE) begin
            tests_failed++; $display("FAIL prio_host_write word2=%0h state=%0d exp=22 0", w16(2), st16);
        end
        idle16();
    endtask

    task automatic test_starve_hold();
        starve16(4'd7, 4'd9, 32'h5A5A);
        tests_run++;
        if (st16 !== ARB_HOLD || bus16.o_core_hold !== 1'b1) begin
            tests_failed++; $display("FAIL hold_entered state=%0d hold=%0b exp=2 1", st16, bus16.o_core_hold);
        end
        tests_run++;
        if (w16(7) !== 32'h103) begin
            tests_failed++; $display("FAIL hold_core_stores word7 got=%0h exp=103", w16(7));
        end
        #1;
        tests_run++;
        if (bus16.o_host_ready !== 1'b1) begin
            tests_failed++; $display("FAIL hold_ready got=%0b exp=1", bus16.o_host_ready);
        end
    endtask

    // Runs right after test_starve_hold, still in HOLD at this point.
    task automatic test_hold_drop();
        bus16.i_core_we = 1; bus16.i_core_sel = 4'd5; bus16.i_core_word = 32'hBEEF;
        @(negedge clk);
        tests_run++;
        if (w16(5) !== 32'h0) begin
            tests_failed++; $display("FAIL drop_word5 got=%0h exp=0", w16(5));
        end
        tests_run++;
        if (w16(9) !== 32'h5A5A) begin
            tests_failed++; $display("FAIL drop_host_write word9 got=%0h exp=5a5a", w16(9));
        end
        tests_run++;
        if (bus16.o_err !== 1'b1) begin
            tests_failed++; $display("FAIL drop_err got=%0b exp=1", bus16.o_err);
        end
        tests_run++;
        if (st16 !== ARB_IDLE || bus16.o_core_hold !== 1'b0) begin
            tests_failed++; $display("FAIL drop_exit state=%0d hold=%0b exp=0 0", st16, bus16.o_core_hold);
        end
        idle16();
        repeat (3) @(negedge clk);
        tests_run++;
        if (bus16.o_err !== 1'b1) begin
            tests_failed++; $display("FAIL drop_err_sticky got=%0b exp=1", bus16.o_err);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] tbl [4];
        tbl[0] = 32'hDEAD_0001; tbl[1] = 32'h1234_5678; tbl[2] = 32'hFFFF_FFFF; tbl[3] = 32'h0F0F_0F0F;
        for (int i = 0; i <= 4; i++) begin
            @(negedge clk);
            if (i > 0) begin
                tests_run++;
                if (w16(10 + i - 1) !== tbl[i-1]) begin
                    tests_failed++; $display("FAIL b2b_write[%0d] got=%0h exp=%0h", i - 1, w16(10 + i - 1), tbl[i-1]);
                end
            end
            if (i < 4) host16(1'b1, 4'(10 + i), tbl[i]);
            else idle16();
        end
        for (int i = 0; i <= 4; i++) begin
            @(negedge clk);
            if (i > 0) begin
                tests_run++;
                if (bus16.o_host_rvalid !== 1'b1 || bus16.o_host_rdata !== tbl[i-1]) begin
                    tests_failed++;
                    $display("FAIL b2b_read[%0d] rvalid=%0b rdata=%0h exp=1 %0h", i - 1,
                             bus16.o_host_rvalid, bus16.o_host_rdata, tbl[i-1]);
                end
            end
            if (i < 4) host16(1'b0, 4'(10 + i), 32'h0);
            else idle16();
        end
    endtask

    task automatic test_max_wait_one();
        @(negedge clk);
        bus12.i_core_we = 1; bus12.i_core_sel = 4'd1; bus12.i_core_word = 32'h77;
        host12(1'b1, 4'd2, 32'h88);
        #1;
        tests_run++;
        if (bus12.o_host_ready !== 1'b0) begin
            tests_failed++; $display("FAIL mw1_blocked ready got=%0b exp=0", bus12.o_host_ready);
        end
        @(negedge clk);
        tests_run++;
        if (st12 !== ARB_HOLD || bus12.o_core_hold !== 1'b1 || w12(1) !== 32'h77) begin
            tests_failed++;
            $display("FAIL mw1_hold state=%0d hold=%0b word1=%0h exp=2 1 77", st12, bus12.o_core_hold, w12(1));
        end
        bus12.i_core_we = 0;
        @(negedge clk);
        tests_run++;
        if (w12(2) !== 32'h88 || st12 !== ARB_IDLE || bus12.o_core_hold !== 1'b0) begin
            tests_failed++;
            $display("FAIL mw1_accept word2=%0h state=%0d hold=%0b exp=88 0 0", w12(2), st12, bus12.o_core_hold);
        end
        idle12();
    endtask

    task automatic test_out_of_range();
        logic [12*32-1:0] exp12;
        exp12 = '0;
        exp12[1*32 +: 32] = 32'h77;
        exp12[2*32 +: 32] = 32'h88;
        exp12[4*32 +: 32] = 32'h33;
        @(negedge clk);
        host12(1'b1, 4'd4, 32'h33);
        @(negedge clk);
        host12(1'b1, 4'd13, 32'hFFFF_FFFF);
        @(negedge clk);
        tests_run++;
        if (bus12.o_mem !== exp12) begin
            tests_failed++; $display("FAIL oor_write got=%0h exp=%0h", bus12.o_mem, exp12);
        end
        host12(1'b0, 4'd4, 32'h0);
        @(negedge clk);
        tests_run++;
        if (bus12.o_host_rvalid !== 1'b1 || bus12.o_host_rdata !== 32'h33) begin
            tests_failed++;
            $display("FAIL oor_read_ok rvalid=%0b rdata=%0h exp=1 33", bus12.o_host_rvalid, bus12.o_host_rdata);
        end
        host12(1'b0, 4'd13, 32'h0);
        @(negedge clk);
        tests_run++;
        if (bus12.o_host_rvalid !== 1'b1 || bus12.o_host_rdata !== 32'h0) begin
            tests_failed++;
            $display("FAIL oor_read rvalid=%0b rdata=%0h exp=1 0", bus12.o_host_rvalid, bus12.o_host_rdata);
        end
        idle12();
    endtask

    task automatic test_reset_mid_hold();
        starve16(4'd6, 4'd8, 32'h4444);
        tests_run++;
        if (bus16.o_core_hold !== 1'b1) begin
            tests_failed++; $display("FAIL rst_hold_pre hold got=%0b exp=1", bus16.o_core_hold);
        end
        #2 rst = 0;
        #1;
        tests_run++;
        if (bus16.o_core_hold !== 1'b0 || st16 !== ARB_IDLE) begin
            tests_failed++; $display("FAIL rst_hold_async hold=%0b state=%0d exp=0 0", bus16.o_core_hold, st16);
        end
        tests_run++;
        if (bus16.o_mem !== '0 || bus16.o_err !== 1'b0 || bus12.o_mem !== '0) begin
            tests_failed++;
            $display("FAIL rst_hold_clear err=%0b mem16=%0h exp=0 0", bus16.o_err, bus16.o_mem);
        end
        idle16();
        @(negedge clk);
        rst = 1;
        @(negedge clk);
    endtask

    // ---------------- sequence / report ----------------
    initial begin
        test_reset();
        test_basic_rw();
        test_core_priority();
        test_starve_hold();
        test_hold_drop();
        test_back_to_back();
        test_max_wait_one();
        test_out_of_range();
        test_reset_mid_hold();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout after %0d tests", tests_run);
        $fatal(1, "watchdog");
    end

endmodule
